// File: rtl/fbcpu_mem_loader.sv
//------------------------------------------------------------------------------
// fbcpu_mem_loader
//   FBCPU program RAM with a streaming boot loader.
//   Holds the core in reset while the RAM is filled, then hands the port over.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fbcpu_mem_loader #(
   parameter int ADDRESS_WIDTH = 6,
   parameter int DATA_WIDTH    = 10,
   parameter int LOAD_COUNT    = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_start,
   input  logic                     ld_valid,
   input  logic [DATA_WIDTH-1:0]    ld_data,
   output logic                     ld_ready,
   output logic                     cpu_rst,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH:0]   word_count,
   input  logic [ADDRESS_WIDTH-1:0] cpu_MAR,
   input  logic                     cpu_RAMWr,
   input  logic [DATA_WIDTH-1:0]    cpu_MDRIn,
   output logic [DATA_WIDTH-1:0]    MDROut
);

   localparam int                   C_DEPTH = 1 << ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH:0] C_LAST = (ADDRESS_WIDTH+1)'(LOAD_COUNT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic                     w_start_load;
   logic                     w_accept;
   logic                     w_cpu_wr;
   logic [ADDRESS_WIDTH-1:0] w_rd_addr;
   logic [ADDRESS_WIDTH-1:0] r_ptr;
   logic [ADDRESS_WIDTH:0]   r_count;
   logic [DATA_WIDTH-1:0]    r_rdata;
   logic [DATA_WIDTH-1:0]    r_mem [0:C_DEPTH-1];

   assign w_accept  = ld_valid & (r_state == S_LOAD);
   assign w_cpu_wr  = cpu_RAMWr & (r_state == S_RUN);
   assign w_rd_addr = (r_state == S_RUN) ? cpu_MAR : r_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // load_start is only honoured outside LOAD, so a reload cannot restart
   // a load that is already in flight.
   always_comb begin
      w_state_next = r_state;
      w_start_load = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (load_start) begin
               w_state_next = S_LOAD;
               w_start_load = 1'b1;
            end
         end
         S_LOAD: begin
            if (w_accept && (r_count == C_LAST)) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (load_start) begin
               w_state_next = S_LOAD;
               w_start_load = 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (w_start_load) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (w_accept) begin
         r_ptr   <= r_ptr + ADDRESS_WIDTH'(1);
         r_count <= r_count + (ADDRESS_WIDTH+1)'(1);
      end
   end

   // RAM contents survive reset; loader and core writes are exclusive by state.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_ptr] <= ld_data;
      end else if (w_cpu_wr) begin
         r_mem[cpu_MAR] <= cpu_MDRIn;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[w_rd_addr];
      end
   end

   assign ld_ready   = (r_state == S_LOAD);
   assign busy       = (r_state == S_LOAD);
   assign done       = (r_state == S_RUN);
   assign cpu_rst    = (r_state != S_RUN);
   assign word_count = r_count;
   assign MDROut     = r_rdata;

endmodule

`default_nettype wire

// File: doc/fbcpu_mem_loader.md
# fbcpu_mem_loader

Program memory and boot loader for the FBCPU core. Holds the 2^ADDRESS_WIDTH x DATA_WIDTH RAM. After reset or a reload request, it fills the RAM from a valid/ready word stream and keeps the core in reset while it does so. Once the last word is written, it releases the core and gives it the RAM port, with a one-cycle registered read.

## Interface
- ADDRESS_WIDTH, 6, RAM address width; depth = 2^ADDRESS_WIDTH.
- DATA_WIDTH, 10, RAM word width.
- LOAD_COUNT, 64, words accepted per load, legal 1..2^ADDRESS_WIDTH; written to addresses 0..LOAD_COUNT-1.

- clk  in  1  sole clock, rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- load_start  in  1  single-cycle reload request.
- ld_valid  in  1  ld_data holds a word.
- ld_data  in  DATA_WIDTH  word to load.
- ld_ready  out  1  loader accepts a word this cycle.
- cpu_rst  out  1  active-high synchronous reset to the core.
- busy  out  1  load in progress.
- done  out  1  core running from loaded image.
- word_count  out  ADDRESS_WIDTH+1  words accepted in the current or last load.
- cpu_MAR  in  ADDRESS_WIDTH  core address.
- cpu_RAMWr  in  1  core write strobe.
- cpu_MDRIn  in  DATA_WIDTH  core write data.
- MDROut  out  DATA_WIDTH  registered read data to the core.

## Operation
- States:
  - IDLE (after reset): IDLE -> LOAD when load_start=1.
  - LOAD: LOAD -> RUN on acceptance of word LOAD_COUNT-1.
  - RUN: RUN -> LOAD when load_start=1. load_start is ignored in LOAD.
- Decoded from the state register, with no combinational path from inputs:
  - ld_ready = busy = (state==LOAD).
  - done = (state==RUN).
  - cpu_rst = (state!=RUN).
- Entering LOAD clears the write pointer and word_count to 0.
- Accept = ld_valid & ld_ready. Each accept writes mem[pointer] <= ld_data, then increments the pointer and word_count.
- ld_valid while ld_ready=0 has no effect; the source must hold the word.
- RUN behaviour:
  - Read address = cpu_MAR; MDROut <= mem[cpu_MAR] every edge.
  - cpu_RAMWr=1 writes mem[cpu_MAR] <= cpu_MDRIn at the edge.
- Read during write to the same address returns the old data.
- In IDLE and LOAD:
  - cpu_RAMWr is ignored.
  - MDROut <= mem[pointer] (don't-care to the core).
- Addresses wrap modulo 2^ADDRESS_WIDTH; word_count never exceeds LOAD_COUNT.
- Reset values: state IDLE, cpu_rst 1, ld_ready 0, busy 0, done 0, word_count 0, MDROut 0, pointer 0. RAM contents are not reset.
- Reset mid-load: the load is aborted and the block returns to IDLE. Words already written stay in RAM, and a new load_start starts again from address 0.
- load_start in RUN aborts the program. cpu_rst rises after that edge, so the core is reset on every edge through the new load.

## Timing
- Write latency: an accepted word is in RAM after the accepting edge.
- Sustained throughput: one word per cycle while ld_valid stays high.
- If the last word is accepted at edge k:
  - RUN and cpu_rst=0 from edge k.
  - The core was in reset at edge k, so it begins the fetch at PC 0 in the cycle after edge k.
  - The core's MAR for that fetch is presented in that cycle.
  - MDROut shows mem[MAR] after edge k+1, which matches the core's fetch/decode step.
- Read latency: MDROut = mem[cpu_MAR sampled at the previous edge], exactly 1 cycle.
- load_start at edge j in IDLE or RUN: ld_ready=1 and cpu_rst=1 from edge j.
- Asynchronous reset takes effect immediately. Release is clean when rst rises away from the clk edge.

## Test plan
- LOAD_COUNT=4, stream 0x3FF,0x001,0x155,0x2AA back-to-back -> ld_ready high exactly 4 cycles, word_count=4, done=1, cpu_rst=0; RUN reads of addresses 0..3 return those words one cycle after the address.
- Same stream with ld_valid low every other cycle -> 8 cycles in LOAD, same RAM contents, no duplicated or skipped words.
- End-to-end with the FBCPU core, LOAD_COUNT=13. Image: mem0=0x00A (LOAD 10), mem1=0x08B (ADD 11), mem2=0x04C (STORE 12), mem3=0x240 (HALT), mem10=5, mem11=7. Expect mem12=12 and the core halted with PC=4.
- In RUN, pulse load_start -> cpu_rst=1 next cycle, word_count=0; a new 4-word image loads and the core restarts at PC 0.
- Drive rst=0 after 2 of 4 words -> immediate IDLE, ld_ready=0, cpu_rst=1, word_count=0; mem0..1 keep their written values.
- In LOAD, drive cpu_RAMWr=1 with cpu_MAR=5 and cpu_MDRIn=0x123 -> mem5 unchanged after load; in RUN the same stimulus writes 0x123.
